// File: rtl/usb_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_pkt_ctrl
// Purpose  : USB receive packet controller. Walks an OUT transaction byte by
//            byte and validates PIDs, CRC results and payload length. Tracks
//            the DATA0/DATA1 toggle, writes payload bytes to the FIFO, and
//            enforces an inter-packet timeout.
// Revision : 1.0  initial release
// ============================================================================
module usb_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'h80,
    parameter logic [7:0] TOKEN_PID      = 8'h96,
    parameter logic [7:0] DATA0_PID      = 8'h3C,
    parameter logic [7:0] DATA1_PID      = 8'hB4,
    parameter logic [7:0] HS_PID         = 8'h2D,
    parameter int         MAX_PAYLOAD    = 64,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       byte_received,
    input  logic [7:0] rcv_byte,
    input  logic       eop,
    input  logic       crc5_ok,
    input  logic       crc16_ok,
    output logic       rcving,
    output logic       w_enable,
    output logic [7:0] w_data,
    output logic       pkt_done,
    output logic [1:0] pkt_type,
    output logic       data_toggle,
    output logic       r_error
);

    localparam int c_CW = $clog2(MAX_PAYLOAD + 4);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_SYNC       = 3'd1;
    localparam logic [2:0] c_PID        = 3'd2;
    localparam logic [2:0] c_TOKEN_BODY = 3'd3;
    localparam logic [2:0] c_DATA_BODY  = 3'd4;
    localparam logic [2:0] c_HS_EOP     = 3'd5;
    localparam logic [2:0] c_ERR        = 3'd6;

    localparam logic [1:0] c_EXP_TOKEN  = 2'd0;
    localparam logic [1:0] c_EXP_DATA   = 2'd1;
    localparam logic [1:0] c_EXP_HS     = 2'd2;

    localparam logic [1:0] c_TYPE_TOKEN = 2'd0;
    localparam logic [1:0] c_TYPE_DATA  = 2'd1;
    localparam logic [1:0] c_TYPE_HS    = 2'd2;

    localparam logic [c_CW-1:0] c_CNT_TWO   = c_CW'(2);
    localparam logic [c_CW-1:0] c_CNT_THREE = c_CW'(3);
    localparam logic [c_CW-1:0] c_CNT_LIMIT = c_CW'(MAX_PAYLOAD + 2);
    localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]      r_state;
    logic [1:0]      r_phase;
    logic [c_CW-1:0] r_cnt;
    logic [c_TW-1:0] r_tmo_cnt;
    logic [7:0]      r_h0;
    logic [7:0]      r_h1;

    logic [2:0]      w_state_nxt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic [c_CW-1:0] w_cnt_inc;
    logic [7:0]      w_exp_pid;
    logic            w_pid_ok;
    logic            w_good;
    logic [1:0]      w_good_type;
    logic            w_fault;
    logic            w_timeout;
    logic            w_write;
    logic            w_shift;

    logic            w_rcving_nxt;
    logic            w_error_nxt;
    logic [1:0]      w_phase_nxt;
    logic            w_toggle_nxt;
    logic [1:0]      w_type_nxt;
    logic [7:0]      w_wdata_nxt;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        case (r_phase)
            c_EXP_DATA: w_exp_pid = data_toggle ? DATA1_PID : DATA0_PID;
            c_EXP_HS:   w_exp_pid = HS_PID;
            default:    w_exp_pid = TOKEN_PID;
        endcase
    end

    // The nibble check also guards against a mis-configured PID parameter.
    assign w_pid_ok = (rcv_byte[7:4] == ~rcv_byte[3:0]) && (rcv_byte == w_exp_pid);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_good      = 1'b0;
        w_good_type = c_TYPE_TOKEN;
        w_fault     = 1'b0;
        w_timeout   = 1'b0;
        w_write     = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (d_edge) begin
                    w_state_nxt = c_SYNC;
                end else if ((r_phase != c_EXP_TOKEN) && (r_tmo_cnt == c_TMO_LAST)) begin
                    w_timeout = 1'b1;
                end
            end
            c_SYNC: begin
                if (byte_received) begin
                    if (rcv_byte == SYNC_BYTE) begin
                        w_state_nxt = c_PID;
                    end else begin
                        w_fault = 1'b1;
                    end
                end
                // A packet cannot end before its PID, whatever the byte was.
                if (eop) begin
                    w_fault = 1'b1;
                end
            end
            c_PID: begin
                if (byte_received) begin
                    if (!w_pid_ok) begin
                        w_fault = 1'b1;
                    end else begin
                        case (r_phase)
                            c_EXP_DATA: w_state_nxt = c_DATA_BODY;
                            c_EXP_HS:   w_state_nxt = c_HS_EOP;
                            default:    w_state_nxt = c_TOKEN_BODY;
                        endcase
                    end
                end
                if (eop && !w_fault) begin
                    if (byte_received && (r_phase == c_EXP_HS)) begin
                        w_good      = 1'b1;
                        w_good_type = c_TYPE_HS;
                    end else begin
                        w_fault = 1'b1;
                    end
                end
            end
            c_TOKEN_BODY: begin
                w_cnt_nxt = r_cnt;
                if (byte_received) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc > c_CNT_TWO) begin
                        w_fault = 1'b1;
                    end
                end
                if (eop && !w_fault) begin
                    if ((w_cnt_nxt == c_CNT_TWO) && crc5_ok) begin
                        w_good      = 1'b1;
                        w_good_type = c_TYPE_TOKEN;
                    end else begin
                        w_fault = 1'b1;
                    end
                end
            end
            c_DATA_BODY: begin
                w_cnt_nxt = r_cnt;
                if (byte_received) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc > c_CNT_LIMIT) begin
                        w_fault = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                        w_write = (r_cnt >= c_CNT_TWO);
                    end
                end
                // The two held-back bytes are the CRC16 and never reach the FIFO.
                if (eop && !w_fault) begin
                    if ((w_cnt_nxt >= c_CNT_THREE) && crc16_ok) begin
                        w_good      = 1'b1;
                        w_good_type = c_TYPE_DATA;
                    end else begin
                        w_fault = 1'b1;
                    end
                end
            end
            c_HS_EOP: begin
                if (byte_received) begin
                    w_fault = 1'b1;
                end else if (eop) begin
                    w_good      = 1'b1;
                    w_good_type = c_TYPE_HS;
                end
            end
            c_ERR: begin
                if (eop) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
        if (w_fault) begin
            w_state_nxt = eop ? c_IDLE : c_ERR;
        end else if (w_good) begin
            w_state_nxt = c_IDLE;
        end
    end

    // ---------------------------------------------------------------- output decode
    always_comb begin
        w_rcving_nxt = (w_state_nxt != c_IDLE);
        w_error_nxt  = r_error;
        w_phase_nxt  = r_phase;
        w_toggle_nxt = data_toggle;
        w_type_nxt   = pkt_type;
        w_wdata_nxt  = w_write ? r_h0 : w_data;
        if ((r_state == c_IDLE) && d_edge) begin
            w_error_nxt = 1'b0;
        end
        if (w_fault || w_timeout) begin
            w_error_nxt = 1'b1;
            w_phase_nxt = c_EXP_TOKEN;
        end else if (w_good) begin
            w_type_nxt = w_good_type;
            case (w_good_type)
                c_TYPE_TOKEN: w_phase_nxt = c_EXP_DATA;
                c_TYPE_DATA: begin
                    w_phase_nxt  = c_EXP_HS;
                    w_toggle_nxt = ~data_toggle;
                end
                default:      w_phase_nxt = c_EXP_TOKEN;
            endcase
        end
    end

    // ---------------------------------------------------------------- registered outputs and datapath
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_phase     <= c_EXP_TOKEN;
            r_cnt       <= '0;
            r_tmo_cnt   <= '0;
            r_h0        <= '0;
            r_h1        <= '0;
            rcving      <= 1'b0;
            w_enable    <= 1'b0;
            w_data      <= '0;
            pkt_done    <= 1'b0;
            pkt_type    <= c_TYPE_TOKEN;
            data_toggle <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_cnt       <= w_cnt_nxt;
            rcving      <= w_rcving_nxt;
            w_enable    <= w_write;
            w_data      <= w_wdata_nxt;
            pkt_done    <= w_good;
            pkt_type    <= w_type_nxt;
            data_toggle <= w_toggle_nxt;
            r_error     <= w_error_nxt;
            if (w_shift) begin
                r_h0 <= r_h1;
                r_h1 <= rcv_byte;
            end
            // Counts idle clocks inside a transaction; wraps to zero on expiry.
            if ((r_state == c_IDLE) && !d_edge && (r_phase != c_EXP_TOKEN) && !w_timeout) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_pkt_ctrl
// Purpose  : Directed self-checking bench for usb_rx_pkt_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_usb_rx_pkt_ctrl;

    localparam int c_MAX = 64;
    localparam int c_TMO = 1024;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_edge;
    logic       byte_received;
    logic [7:0] rcv_byte;
    logic       eop;
    logic       crc5_ok;
    logic       crc16_ok;
    logic       rcving;
    logic       w_enable;
    logic [7:0] w_data;
    logic       pkt_done;
    logic [1:0] pkt_type;
    logic       data_toggle;
    logic       r_error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] wr_q[$];
    logic [1:0] done_q[$];

    usb_rx_pkt_ctrl #(
        .SYNC_BYTE      (8'h80),
        .TOKEN_PID      (8'h96),
        .DATA0_PID      (8'h3C),
        .DATA1_PID      (8'hB4),
        .HS_PID         (8'h2D),
        .MAX_PAYLOAD    (c_MAX),
        .TIMEOUT_CYCLES (c_TMO)
    ) u_dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_edge        (d_edge),
        .byte_received (byte_received),
        .rcv_byte      (rcv_byte),
        .eop           (eop),
        .crc5_ok       (crc5_ok),
        .crc16_ok      (crc16_ok),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .w_data        (w_data),
        .pkt_done      (pkt_done),
        .pkt_type      (pkt_type),
        .data_toggle   (data_toggle),
        .r_error       (r_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (w_enable) wr_q.push_back(w_data);
        if (pkt_done) done_q.push_back(pkt_type);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_edge();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        byte_received = 1'b1;
        rcv_byte      = b;
        tick();
        byte_received = 1'b0;
    endtask

    task automatic put_eop(input logic c5, input logic c16);
        eop      = 1'b1;
        crc5_ok  = c5;
        crc16_ok = c16;
        tick();
        eop      = 1'b0;
        crc5_ok  = 1'b0;
        crc16_ok = 1'b0;
    endtask

    task automatic send_token();
        pulse_edge();
        put_byte(8'h80);
        put_byte(8'h96);
        put_byte(8'h12);
        put_byte(8'h34);
        put_eop(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        n_rst = 1'b1; d_edge = 1'b0; byte_received = 1'b0; rcv_byte = 8'h00;
        eop = 1'b0; crc5_ok = 1'b0; crc16_ok = 1'b0;
        #2 n_rst = 1'b0;
        repeat (3) tick();
        n_cmp++; if (rcving !== 1'b0)      begin n_bad++; $display("FAIL reset_rcving got %b exp 0", rcving); end
        n_cmp++; if (w_enable !== 1'b0)    begin n_bad++; $display("FAIL reset_w_enable got %b exp 0", w_enable); end
        n_cmp++; if (w_data !== 8'h00)     begin n_bad++; $display("FAIL reset_w_data got %h exp 00", w_data); end
        n_cmp++; if (pkt_done !== 1'b0)    begin n_bad++; $display("FAIL reset_pkt_done got %b exp 0", pkt_done); end
        n_cmp++; if (pkt_type !== 2'd0)    begin n_bad++; $display("FAIL reset_pkt_type got %0d exp 0", pkt_type); end
        n_cmp++; if (data_toggle !== 1'b0) begin n_bad++; $display("FAIL reset_toggle got %b exp 0", data_toggle); end
        n_cmp++; if (r_error !== 1'b0)     begin n_bad++; $display("FAIL reset_r_error got %b exp 0", r_error); end
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_good_transaction();
        int w0, d0;
        logic [31:0] got_w;
        logic [5:0]  got_t;
        w0 = wr_q.size(); d0 = done_q.size();
        pulse_edge();
        n_cmp++; if (rcving !== 1'b1) begin n_bad++; $display("FAIL good_rcving_rise got %b exp 1", rcving); end
        put_byte(8'h80); put_byte(8'h96); put_byte(8'h12); put_byte(8'h34);
        put_eop(1'b1, 1'b0);
        n_cmp++; if (pkt_done !== 1'b1) begin n_bad++; $display("FAIL good_tok_done got %b exp 1", pkt_done); end
        n_cmp++; if (pkt_type !== 2'd0) begin n_bad++; $display("FAIL good_tok_type got %0d exp 0", pkt_type); end
        n_cmp++; if (rcving !== 1'b0)   begin n_bad++; $display("FAIL good_tok_rcving got %b exp 0", rcving); end
        tick();
        pulse_edge();
        put_byte(8'h80); put_byte(8'h3C); put_byte(8'h11); put_byte(8'h22); put_byte(8'h33);
        n_cmp++; if (w_enable !== 1'b1) begin n_bad++; $display("FAIL good_first_wen got %b exp 1", w_enable); end
        n_cmp++; if (w_data !== 8'h11)  begin n_bad++; $display("FAIL good_first_wdata got %h exp 11", w_data); end
        put_byte(8'h44); put_byte(8'hC1); put_byte(8'hC2);
        put_eop(1'b0, 1'b1);
        n_cmp++; if (pkt_done !== 1'b1)    begin n_bad++; $display("FAIL good_data_done got %b exp 1", pkt_done); end
        n_cmp++; if (pkt_type !== 2'd1)    begin n_bad++; $display("FAIL good_data_type got %0d exp 1", pkt_type); end
        n_cmp++; if (data_toggle !== 1'b1) begin n_bad++; $display("FAIL good_data_toggle got %b exp 1", data_toggle); end
        tick();
        pulse_edge();
        put_byte(8'h80); put_byte(8'h2D);
        put_eop(1'b0, 1'b0);
        n_cmp++; if (pkt_done !== 1'b1) begin n_bad++; $display("FAIL good_hs_done got %b exp 1", pkt_done); end
        n_cmp++; if (pkt_type !== 2'd2) begin n_bad++; $display("FAIL good_hs_type got %0d exp 2", pkt_type); end
        n_cmp++; if (r_error !== 1'b0)  begin n_bad++; $display("FAIL good_r_error got %b exp 0", r_error); end
        tick();
        got_w = '0;
        for (int i = 0; i < 4; i++) if (w0 + i < wr_q.size()) got_w = {got_w[23:0], wr_q[w0 + i]};
        got_t = '0;
        for (int i = 0; i < 3; i++) if (d0 + i < done_q.size()) got_t = {got_t[3:0], done_q[d0 + i]};
        n_cmp++; if (wr_q.size() - w0 != 4)   begin n_bad++; $display("FAIL good_wr_count got %0d exp 4", wr_q.size() - w0); end
        n_cmp++; if (got_w !== 32'h11223344)  begin n_bad++; $display("FAIL good_wr_data got %h exp 11223344", got_w); end
        n_cmp++; if (done_q.size() - d0 != 3) begin n_bad++; $display("FAIL good_done_count got %0d exp 3", done_q.size() - d0); end
        n_cmp++; if (got_t !== 6'b00_01_10)   begin n_bad++; $display("FAIL good_done_types got %b exp 000110", got_t); end
    endtask

    task automatic test_toggle_mismatch();
        send_token();
        n_cmp++; if (pkt_done !== 1'b1) begin n_bad++; $display("FAIL tgl_tok_done got %b exp 1", pkt_done); end
        tick();
        pulse_edge();
        put_byte(8'h80); put_byte(8'h3C);
        n_cmp++; if (r_error !== 1'b1)     begin n_bad++; $display("FAIL tgl_r_error got %b exp 1", r_error); end
        n_cmp++; if (data_toggle !== 1'b1) begin n_bad++; $display("FAIL tgl_toggle got %b exp 1", data_toggle); end
        n_cmp++; if (rcving !== 1'b1)      begin n_bad++; $display("FAIL tgl_rcving_err got %b exp 1", rcving); end
        put_byte(8'h01);
        put_eop(1'b0, 1'b1);
        n_cmp++; if (rcving !== 1'b0)   begin n_bad++; $display("FAIL tgl_rcving_close got %b exp 0", rcving); end
        n_cmp++; if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL tgl_done got %b exp 0", pkt_done); end
        tick();
    endtask

    task automatic test_bad_pid();
        int w0;
        w0 = wr_q.size();
        pulse_edge();
        n_cmp++; if (r_error !== 1'b0) begin n_bad++; $display("FAIL badpid_clear_on_edge got %b exp 0", r_error); end
        put_byte(8'h80); put_byte(8'h97);
        n_cmp++; if (r_error !== 1'b1) begin n_bad++; $display("FAIL badpid_r_error got %b exp 1", r_error); end
        put_byte(8'h55);
        put_eop(1'b1, 1'b1);
        n_cmp++; if (rcving !== 1'b0)  begin n_bad++; $display("FAIL badpid_rcving got %b exp 0", rcving); end
        n_cmp++; if (r_error !== 1'b1) begin n_bad++; $display("FAIL badpid_sticky got %b exp 1", r_error); end
        tick();
        pulse_edge();
        n_cmp++; if (r_error !== 1'b0) begin n_bad++; $display("FAIL badpid_recover got %b exp 0", r_error); end
        put_eop(1'b0, 1'b0);
        n_cmp++; if (r_error !== 1'b1) begin n_bad++; $display("FAIL sync_eop_err got %b exp 1", r_error); end
        tick();
        n_cmp++; if (wr_q.size() != w0) begin n_bad++; $display("FAIL badpid_no_write got %0d exp 0", wr_q.size() - w0); end
    endtask

    task automatic test_overflow();
        int   w0;
        logic early;
        send_token();
        tick();
        pulse_edge();
        put_byte(8'h80); put_byte(8'hB4);
        w0 = wr_q.size();
        early = 1'b0;
        for (int i = 1; i <= c_MAX + 3; i++) begin
            put_byte(i[7:0]);
            if (i < c_MAX + 3 && r_error) early = 1'b1;
        end
        n_cmp++; if (early !== 1'b0)   begin n_bad++; $display("FAIL ovf_early_err got %b exp 0", early); end
        n_cmp++; if (r_error !== 1'b1) begin n_bad++; $display("FAIL ovf_r_error got %b exp 1", r_error); end
        put_eop(1'b0, 1'b1);
        tick();
        n_cmp++; if (wr_q.size() - w0 != c_MAX) begin n_bad++; $display("FAIL ovf_wr_count got %0d exp %0d", wr_q.size() - w0, c_MAX); end
        n_cmp++; if (wr_q.size() > w0 && wr_q[w0] !== 8'h01) begin n_bad++; $display("FAIL ovf_first_byte got %h exp 01", wr_q[w0]); end
        n_cmp++; if (data_toggle !== 1'b1) begin n_bad++; $display("FAIL ovf_toggle got %b exp 1", data_toggle); end
    endtask

    task automatic test_timeout();
        send_token();
        n_cmp++; if (pkt_done !== 1'b1) begin n_bad++; $display("FAIL tmo_tok_done got %b exp 1", pkt_done); end
        repeat (c_TMO - 1) tick();
        n_cmp++; if (r_error !== 1'b0) begin n_bad++; $display("FAIL tmo_early got %b exp 0", r_error); end
        tick();
        n_cmp++; if (r_error !== 1'b1) begin n_bad++; $display("FAIL tmo_on_time got %b exp 1", r_error); end
        pulse_edge();
        n_cmp++; if (r_error !== 1'b0) begin n_bad++; $display("FAIL tmo_clear got %b exp 0", r_error); end
        put_byte(8'h80); put_byte(8'hB4);
        n_cmp++; if (r_error !== 1'b1) begin n_bad++; $display("FAIL tmo_data_rejected got %b exp 1", r_error); end
        put_eop(1'b0, 1'b1);
        n_cmp++; if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL tmo_done got %b exp 0", pkt_done); end
        tick();
    endtask

    task automatic test_crc_bad_and_reset();
        send_token();
        tick();
        pulse_edge();
        put_byte(8'h80); put_byte(8'hB4); put_byte(8'h01); put_byte(8'h02); put_byte(8'h03);
        put_eop(1'b0, 1'b0);
        n_cmp++; if (r_error !== 1'b1)     begin n_bad++; $display("FAIL crc_r_error got %b exp 1", r_error); end
        n_cmp++; if (pkt_done !== 1'b0)    begin n_bad++; $display("FAIL crc_done got %b exp 0", pkt_done); end
        n_cmp++; if (data_toggle !== 1'b1) begin n_bad++; $display("FAIL crc_toggle got %b exp 1", data_toggle); end
        n_cmp++; if (rcving !== 1'b0)      begin n_bad++; $display("FAIL crc_rcving got %b exp 0", rcving); end
        tick();
        send_token();
        tick();
        pulse_edge();
        put_byte(8'h80); put_byte(8'hB4); put_byte(8'h05); put_byte(8'h06); put_byte(8'h07);
        n_cmp++; if (w_enable !== 1'b1) begin n_bad++; $display("FAIL rst_pre_wen got %b exp 1", w_enable); end
        n_rst = 1'b0;
        #1;
        n_cmp++; if (w_enable !== 1'b0)    begin n_bad++; $display("FAIL rst_mid_wen got %b exp 0", w_enable); end
        n_cmp++; if (w_data !== 8'h00)     begin n_bad++; $display("FAIL rst_mid_wdata got %h exp 00", w_data); end
        n_cmp++; if (rcving !== 1'b0)      begin n_bad++; $display("FAIL rst_mid_rcving got %b exp 0", rcving); end
        n_cmp++; if (data_toggle !== 1'b0) begin n_bad++; $display("FAIL rst_mid_toggle got %b exp 0", data_toggle); end
        n_cmp++; if (r_error !== 1'b0)     begin n_bad++; $display("FAIL rst_mid_r_error got %b exp 0", r_error); end
        tick();
        n_rst = 1'b1;
        tick();
        pulse_edge();
        put_byte(8'h80); put_byte(8'h3C);
        n_cmp++; if (r_error !== 1'b1) begin n_bad++; $display("FAIL rst_expect_token got %b exp 1", r_error); end
        put_eop(1'b0, 1'b1);
        tick();
    endtask

    initial begin
        test_reset();
        test_good_transaction();
        test_toggle_mismatch();
        test_bad_pid();
        test_overflow();
        test_timeout();
        test_crc_bad_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
